intr_ctrl: RTL

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 32 +++
 rtl/intr_ctrl_edge_sync.sv | 28 ++
 rtl/intr_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings, vector base,
// request codes and small helpers for priority and vector formation.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_t;

  localparam logic [3:0] VEC_BASE  = 4'hF;
  localparam logic [1:0] INTR_NONE = 2'b00;
  localparam int         NUM_SRC   = 3;

  // Highest-numbered eligible source wins: 3 > 2 > 1.
  function automatic logic [1:0] prio_id(input logic [NUM_SRC-1:0] elig);
    if (elig[2])      return 2'd3;
    else if (elig[1]) return 2'd2;
    else if (elig[0]) return 2'd1;
    return INTR_NONE;
  endfunction

  function automatic logic [7:0] make_vec(input logic [1:0] id);
    return {VEC_BASE, id, 2'b00};
  endfunction

  // One-hot pending-bit position of a source id (id 1 -> bit 0).
  function automatic logic [NUM_SRC-1:0] id_bit(input logic [1:0] id);
    return 3'b001 << (id - 2'd1);
  endfunction

endpackage

// File: rtl/intr_ctrl_edge_sync.sv
// Two-flop synchronizer for one asynchronous irq line, followed by a
// single-cycle rising-edge pulse generator.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta_q, sync_q, prev_q;

  // NOTE: non-blocking assignments make all three flops sample the old
  // values together, so the chain shifts instead of collapsing in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Three-source prioritised interrupt controller: synchronised edge capture,
// pending/mask/enable registers and an IDLE/REQ/SERVICE handshake FSM.
module intr_ctrl
  import intr_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] irq,
  input  logic       ack,
  input  logic       eoi,
  input  logic       ie_set,
  input  logic       ie_clr,
  input  logic       mask_we,
  input  logic [2:0] mask_din,
  output logic [1:0] INTR,
  output logic [7:0] vec,
  output logic       in_service,
  output logic [2:0] pend
);

  logic [2:0] rise;
  logic       ie;
  logic [2:0] mask;
  logic [2:0] eligible;
  logic [2:0] pend_clr;

  state_t     state, state_n;
  logic [1:0] id_q, id_n;
  logic [1:0] intr_n;
  logic [7:0] vec_n;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    edge_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (irq[g]),
      .pulse (rise[g])
    );
  end

  // ie_clr has priority over ie_set when both are pulsed together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie   <= 1'b0;
      mask <= 3'b111;
    end else begin
      if (ie_clr)      ie <= 1'b0;
      else if (ie_set) ie <= 1'b1;
      if (mask_we) mask <= mask_din;
    end
  end

  assign eligible = pend & ~mask;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    id_n     = id_q;
    intr_n   = INTR;
    vec_n    = vec;
    pend_clr = '0;
    case (state)
      ST_IDLE: begin
        if (ie && (eligible != '0)) begin
          state_n = ST_REQ;
          id_n    = prio_id(eligible);
          intr_n  = id_n;
          vec_n   = make_vec(id_n);
        end
      end
      ST_REQ: begin
        // ack is taken before the enable check, so a same-cycle ie_clr loses.
        if (ack) begin
          state_n  = ST_SERVICE;
          intr_n   = INTR_NONE;
          pend_clr = id_bit(id_q);
        end else if (!ie) begin
          state_n = ST_IDLE;
          intr_n  = INTR_NONE;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        intr_n  = INTR_NONE;
      end
    endcase
  end

  // NOTE: every flop here is on the asynchronous reset so outputs drop the
  // moment rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      id_q  <= INTR_NONE;
      INTR  <= INTR_NONE;
      vec   <= 8'h00;
      pend  <= '0;
    end else begin
      state <= state_n;
      id_q  <= id_n;
      INTR  <= intr_n;
      vec   <= vec_n;
      // A fresh edge in the same cycle as its ack keeps the source pending.
      pend  <= (pend & ~pend_clr) | rise;
    end
  end

  assign in_service = (state == ST_SERVICE);

endmodule
